// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int MDU_DATA_W = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } mdu_state_e;

    // Operation context captured at start; operands are not re-sampled afterwards.
    typedef struct packed {
        logic op;
        logic sign_a;
        logic sign_b;
    } mdu_req_t;

endpackage

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fix-up.
module mdu_cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg_en,
    output logic [W-1:0] result
);

    assign result = neg_en ? (-value) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV: one shift-add or restoring-divide step per cycle on magnitudes,
// then a single sign-fix cycle that loads HI/LO.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic              w_clk,
    input  logic              w_reset_n,
    input  logic              w_Start,
    input  logic              w_Op,
    input  logic [DATA_W-1:0] w_A,
    input  logic [DATA_W-1:0] w_B,
    output logic [DATA_W-1:0] w_Hi,
    output logic [DATA_W-1:0] w_Lo,
    output logic              w_Busy,
    output logic              w_Done,
    output logic              w_DivZero
);

    mdu_state_e          state;
    mdu_req_t            req;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   a_mag, b_mag, a_abs, b_abs;
    logic [DATA_W-1:0]   acc_hi, acc_lo;
    logic [DATA_W:0]     mul_sum, rem_sh, rem_sub;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    mdu_cond_neg #(.W(DATA_W)) u_abs_a (.value(w_A), .neg_en(w_A[DATA_W-1]), .result(a_abs));
    mdu_cond_neg #(.W(DATA_W)) u_abs_b (.value(w_B), .neg_en(w_B[DATA_W-1]), .result(b_abs));

    mdu_cond_neg #(.W(2*DATA_W)) u_fix_prod (
        .value ({acc_hi, acc_lo}),
        .neg_en(req.sign_a ^ req.sign_b),
        .result(prod_fix)
    );
    mdu_cond_neg #(.W(DATA_W)) u_fix_quo (
        .value (acc_lo),
        .neg_en(req.sign_a ^ req.sign_b),
        .result(quo_fix)
    );
    // Remainder follows the dividend's sign.
    mdu_cond_neg #(.W(DATA_W)) u_fix_rem (
        .value (acc_hi),
        .neg_en(req.sign_a),
        .result(rem_fix)
    );

    // One extra bit keeps the carry of the add and the borrow of the trial subtract.
    assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? a_mag : {DATA_W{1'b0}})};
    assign rem_sh  = {acc_hi, acc_lo[DATA_W-1]};
    assign rem_sub = rem_sh - {1'b0, b_mag};

    always_ff @(posedge w_clk) begin
        if (!w_reset_n) begin
            state     <= IDLE;
            req       <= '0;
            cnt       <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            w_Hi      <= '0;
            w_Lo      <= '0;
            w_Busy    <= 1'b0;
            w_Done    <= 1'b0;
            w_DivZero <= 1'b0;
        end else begin
            w_Done <= 1'b0;
            unique case (state)
                IDLE: if (w_Start) begin
                    req       <= '{op: w_Op, sign_a: w_A[DATA_W-1], sign_b: w_B[DATA_W-1]};
                    a_mag     <= a_abs;
                    b_mag     <= b_abs;
                    cnt       <= CNT_W'(DATA_W);
                    acc_hi    <= '0;
                    acc_lo    <= (w_Op == OP_DIV) ? a_abs : b_abs;
                    w_DivZero <= 1'b0;
                    if (w_Op == OP_DIV && w_B == '0) begin
                        state     <= DONE;
                        w_Done    <= 1'b1;
                        w_DivZero <= 1'b1;
                        w_Hi      <= w_A;
                        w_Lo      <= '1;
                    end else begin
                        state  <= (w_Op == OP_DIV) ? DIV : MUL;
                        w_Busy <= 1'b1;
                    end
                end
                MUL: begin
                    acc_hi <= mul_sum[DATA_W:1];
                    acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                DIV: begin
                    if (!rem_sub[DATA_W]) begin
                        acc_hi <= rem_sub[DATA_W-1:0];
                        acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_hi <= rem_sh[DATA_W-1:0];
                        acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    if (req.op == OP_DIV) begin
                        w_Hi <= rem_fix;
                        w_Lo <= quo_fix;
                    end else begin
                        {w_Hi, w_Lo} <= prod_fix;
                    end
                    w_Busy <= 1'b0;
                    w_Done <= 1'b1;
                    state  <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
